sipo_piso_slave: RTL and testbench
==================================

SIPO_PISO_SLAVE -- requirements
Module: sipo_piso

Interface
- REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
- REQ-002 Port `clk`, input, 1 bit: the only clock; all state changes on its rising edge.
- REQ-003 Port `rst`, input, 1 bit: synchronous, active-high reset.
- REQ-004 Port `strobe`, input, 1 bit: frame start, one-cycle pulse.
- REQ-005 Port `wr_en`, input, 1 bit: frame type, sampled with strobe; 1 = write, 0 = read.
- REQ-006 Port `din`, input, 1 bit: serial data in, LSB first.
- REQ-007 Port `dout`, output, 1 bit: serial read data out, LSB first.
- REQ-008 Port `rw_flag`, output, 1 bit: high while `dout` carries read data (pad output enable).
- REQ-009 Ports `cfg_0`..`cfg_8`, output, 8 bits each: contents of read/write registers at addresses 0..8.
- REQ-010 Ports `rd_1`..`rd_8`, input, 8 bits each: read-only status values at addresses 9..16.
- REQ-011 Parameter ADDR_WIDTH, default 5: address field width.
- REQ-012 Parameter REG_WIDTH, default 8: data field width; frame length is ADDR_WIDTH+REG_WIDTH = 13.

Function
- REQ-013 A frame SHALL start on the clock edge where `strobe`=1; that edge latches `wr_en`, clears the bit counter and clears the shift register.
- REQ-014 Each following rising edge SHALL be one bit slot (count 1..13); after count 13 the block SHALL idle until the next strobe.
- REQ-015 A strobe during an active frame SHALL abort it without committing, and start a new frame.
- REQ-016 Write frame layout on `din`: slots 1..8 carry data bits 0..7, slots 9..13 carry address bits 0..4.
- REQ-017 On the slot-13 edge of a write frame, the data SHALL be written to the addressed register; `cfg_n` SHALL show the new value from that edge.
- REQ-018 Writes to addresses 9..16 (read-only) and 17..31 (unmapped) SHALL be ignored.
- REQ-019 Read frame slots 1..5: `din` SHALL carry address bits 0..4; `din` SHALL be ignored in slots 6..13.
- REQ-020 On the slot-5 edge of a read frame, the output shift register SHALL load the addressed value (0..8 from the register file, 9..16 from `rd_1`..`rd_8`, unmapped = 0x00).
- REQ-021 After the slot-5 edge, `dout` SHALL present data bit 0; after the slot-(5+k) edge it SHALL present bit k, for k = 0..7.
- REQ-022 `dout` SHALL be driven directly from a register bit, with no combinational path from `din`.
- REQ-023 `rw_flag` SHALL be 1 from the slot-5 edge through the slot-12 edge of a read frame, and 0 otherwise.
- REQ-024 `dout` SHALL be 0 whenever `rw_flag` is 0.
- REQ-025 Read frames SHALL NOT modify any register.

Reset
- REQ-026 While `rst`=1 at a clock edge: `cfg_0`..`cfg_8` SHALL go to 0x00, the frame state SHALL go to idle, the shift registers SHALL clear, and `dout`=0 and `rw_flag`=0.
- REQ-027 `rst` SHALL override `strobe`; a reset during a frame SHALL abandon it and commit no write.

Verification
- REQ-028 Write 0x0A2, 0x15D, 0x283, 0x3C6, 0x433, 0x52B, 0x635, 0x715, 0x847 (addr = bits 12:8, data = bits 7:0) -> `cfg_0`..`cfg_8` = A2, 5D, 83, C6, 33, 2B, 35, 15, 47.
- REQ-029 Read addresses 0..8 after REQ-028 -> the 8 bits on `dout` in slots 6..13 equal A2, 5D, 83, C6, 33, 2B, 35, 15, 47; `rw_flag`=1 only in those slots.
- REQ-030 Set `rd_1`..`rd_8` to random values, write frames to addresses 9..16, then read 9..16 -> each read returns the `rd_n` value; no `cfg` output changes.
- REQ-031 Hold `rst` high for one edge mid-frame, then read address 0 -> returns 0x00.
- REQ-032 Write to address 20, then read address 20 -> `cfg` outputs unchanged, read returns 0x00.
- REQ-033 Send a strobe at slot 7 of a write frame, then a complete write of 0x1FF -> only `cfg_1` = FF.

Source files
------------

// File: rtl/sipo_piso_slave.sv
// ---------------------------------------------------------------------------
// sipo_piso_slave
//
// Serial register slave. A one-cycle strobe starts a frame, and each later
// rising edge consumes one bit slot. Write frames shift in 8 data bits and
// then 5 address bits, all LSB first, and commit on the last slot. Read
// frames shift in 5 address bits. The addressed value is then loaded into an
// output shift register and presented on dout, LSB first, for 8 slots.
//
// Ports
//   clk            : the only clock, rising edge
//   rst            : synchronous, active-high reset (overrides strobe)
//   strobe         : frame start pulse; also aborts any frame in progress
//   wr_en          : frame type, sampled with strobe (1 = write, 0 = read)
//   din            : serial data in, LSB first
//   dout           : serial read data out, LSB first, registered
//   rw_flag        : high while dout carries read data (pad output enable)
//   cfg_0..cfg_8   : read/write register contents, addresses 0..8
//   rd_1..rd_8     : read-only status inputs, addresses 9..16
//
// The interface has no valid/ready handshake. Timing is set entirely by the
// strobe and the clock edges that follow it.
// ---------------------------------------------------------------------------
module sipo_piso_slave #(
    parameter int ADDR_WIDTH = 5,
    parameter int REG_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 strobe,
    input  logic                 wr_en,
    input  logic                 din,
    output logic                 dout,
    output logic                 rw_flag,
    output logic [REG_WIDTH-1:0] cfg_0,
    output logic [REG_WIDTH-1:0] cfg_1,
    output logic [REG_WIDTH-1:0] cfg_2,
    output logic [REG_WIDTH-1:0] cfg_3,
    output logic [REG_WIDTH-1:0] cfg_4,
    output logic [REG_WIDTH-1:0] cfg_5,
    output logic [REG_WIDTH-1:0] cfg_6,
    output logic [REG_WIDTH-1:0] cfg_7,
    output logic [REG_WIDTH-1:0] cfg_8,
    input  logic [REG_WIDTH-1:0] rd_1,
    input  logic [REG_WIDTH-1:0] rd_2,
    input  logic [REG_WIDTH-1:0] rd_3,
    input  logic [REG_WIDTH-1:0] rd_4,
    input  logic [REG_WIDTH-1:0] rd_5,
    input  logic [REG_WIDTH-1:0] rd_6,
    input  logic [REG_WIDTH-1:0] rd_7,
    input  logic [REG_WIDTH-1:0] rd_8
);

    localparam int FRAME_LEN = ADDR_WIDTH + REG_WIDTH;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int NUM_CFG   = 9;
    localparam int NUM_RD    = 8;

    localparam logic [CNT_W-1:0] LAST_SLOT    = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] RD_LOAD_SLOT = CNT_W'(ADDR_WIDTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;       // slots consumed so far in this frame
    logic                   wr_q;        // frame type latched at the strobe
    logic [FRAME_LEN-1:0]   shift_q;     // serial input, LSB first, filled from the top
    logic [REG_WIDTH-1:0]   out_q;       // read data, bit 0 drives dout
    logic                   rw_q;
    logic [REG_WIDTH-1:0]   cfg_q [NUM_CFG];
    logic [REG_WIDTH-1:0]   rd_arr [NUM_RD];

    logic [CNT_W-1:0]       slot_now;    // slot number of the current edge
    logic [FRAME_LEN-1:0]   shift_next;
    logic [ADDR_WIDTH-1:0]  addr_next;
    logic [REG_WIDTH-1:0]   data_next;
    logic [REG_WIDTH-1:0]   read_value;
    logic                   in_slot;
    logic                   commit_wr;
    logic                   load_rd;
    logic                   end_frame;

    always_comb begin
        rd_arr[0] = rd_1;
        rd_arr[1] = rd_2;
        rd_arr[2] = rd_3;
        rd_arr[3] = rd_4;
        rd_arr[4] = rd_5;
        rd_arr[5] = rd_6;
        rd_arr[6] = rd_7;
        rd_arr[7] = rd_8;
    end

    // Shifting in at the MSB leaves the address field in the top ADDR_WIDTH
    // bits. That holds after the 5th slot of a read frame and after the last
    // slot of a write frame, so one decode serves both frame types.
    assign slot_now   = cnt_q + CNT_W'(1);
    assign shift_next = {din, shift_q[FRAME_LEN-1:1]};
    assign addr_next  = shift_next[FRAME_LEN-1:REG_WIDTH];
    assign data_next  = shift_next[REG_WIDTH-1:0];

    always_comb begin
        read_value = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (addr_next == ADDR_WIDTH'(i)) read_value = cfg_q[i];
        end
        for (int j = 0; j < NUM_RD; j++) begin
            if (addr_next == ADDR_WIDTH'(NUM_CFG + j)) read_value = rd_arr[j];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: a strobe always (re)starts a frame
    always_comb begin
        state_d = state_q;
        if (strobe)
            state_d = ST_SHIFT;
        else if (state_q == ST_SHIFT && slot_now == LAST_SLOT)
            state_d = ST_IDLE;
    end

    // Output decode: slot events for the current edge
    always_comb begin
        in_slot   = (state_q == ST_SHIFT) && !strobe;
        commit_wr = in_slot && wr_q  && (slot_now == LAST_SLOT);
        load_rd   = in_slot && !wr_q && (slot_now == RD_LOAD_SLOT);
        end_frame = in_slot && (slot_now == LAST_SLOT);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            shift_q <= '0;
            out_q   <= '0;
            rw_q    <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
        end else if (strobe) begin
            cnt_q   <= '0;
            wr_q    <= wr_en;
            shift_q <= '0;
            out_q   <= '0;
            rw_q    <= 1'b0;
        end else if (in_slot) begin
            cnt_q   <= slot_now;
            shift_q <= shift_next;
            if (load_rd) begin
                out_q <= read_value;
                rw_q  <= 1'b1;
            end else if (end_frame) begin
                // Clearing out_q keeps dout low once rw_flag drops
                out_q <= '0;
                rw_q  <= 1'b0;
            end else if (rw_q) begin
                out_q <= out_q >> 1;
            end
            if (commit_wr) begin
                for (int i = 0; i < NUM_CFG; i++) begin
                    if (addr_next == ADDR_WIDTH'(i)) cfg_q[i] <= data_next;
                end
            end
        end
    end

    assign dout    = out_q[0];
    assign rw_flag = rw_q;

    assign cfg_0 = cfg_q[0];
    assign cfg_1 = cfg_q[1];
    assign cfg_2 = cfg_q[2];
    assign cfg_3 = cfg_q[3];
    assign cfg_4 = cfg_q[4];
    assign cfg_5 = cfg_q[5];
    assign cfg_6 = cfg_q[6];
    assign cfg_7 = cfg_q[7];
    assign cfg_8 = cfg_q[8];

endmodule

// File: tb/tb_sipo_piso_slave.sv
// ---------------------------------------------------------------------------
// tb_sipo_piso_slave
//
// Directed bench for sipo_piso_slave. Inputs are driven on the falling edge,
// so each rising edge consumes the values set half a cycle earlier. Outputs
// are sampled on the falling edge. A reference model of the register file
// and status inputs produces every expected value. Expected read data is
// queued when a read frame starts and popped once the byte has been shifted
// out on dout.
// ---------------------------------------------------------------------------
module tb_sipo_piso_slave;

    logic       clk;
    logic       rst;
    logic       strobe;
    logic       wr_en;
    logic       din;
    logic       dout;
    logic       rw_flag;
    logic [7:0] cfg_obs [9];
    logic [7:0] rd_m    [8];

    logic [7:0] cfg_m   [9];
    logic [7:0] exp_q   [$];

    int checks = 0;
    int errors = 0;

    sipo_piso_slave #(.ADDR_WIDTH(5), .REG_WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .strobe  (strobe),
        .wr_en   (wr_en),
        .din     (din),
        .dout    (dout),
        .rw_flag (rw_flag),
        .cfg_0   (cfg_obs[0]),
        .cfg_1   (cfg_obs[1]),
        .cfg_2   (cfg_obs[2]),
        .cfg_3   (cfg_obs[3]),
        .cfg_4   (cfg_obs[4]),
        .cfg_5   (cfg_obs[5]),
        .cfg_6   (cfg_obs[6]),
        .cfg_7   (cfg_obs[7]),
        .cfg_8   (cfg_obs[8]),
        .rd_1    (rd_m[0]),
        .rd_2    (rd_m[1]),
        .rd_3    (rd_m[2]),
        .rd_4    (rd_m[3]),
        .rd_5    (rd_m[4]),
        .rd_6    (rd_m[5]),
        .rd_7    (rd_m[6]),
        .rd_8    (rd_m[7])
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cfg(input string tag);
        for (int i = 0; i < 9; i++) check(tag, cfg_obs[i], cfg_m[i]);
    endtask

    function automatic logic [7:0] model_read(input logic [4:0] addr);
        if (addr < 5'd9)       return cfg_m[int'(addr)];
        else if (addr < 5'd17) return rd_m[int'(addr) - 9];
        else                   return 8'h00;
    endfunction

    // ---------------- drivers ----------------
    task automatic start_frame(input logic w);
        @(negedge clk);
        strobe = 1'b1;
        wr_en  = w;
        din    = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_slot(input logic b);
        @(negedge clk);
        strobe = 1'b0;
        din    = b;
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [7:0] data);
        logic [12:0] frame;
        frame = {addr, data};
        start_frame(1'b1);
        for (int i = 0; i < 13; i++) begin
            drive_slot(frame[i]);
            // Slot 12 has been consumed; nothing may be committed yet
            if (i == 12 && addr < 5'd9)
                check("pre_commit", cfg_obs[int'(addr)], cfg_m[int'(addr)]);
        end
        @(negedge clk);
        if (addr < 5'd9) cfg_m[int'(addr)] = data;
    endtask

    task automatic do_read(input logic [4:0] addr);
        logic [7:0] got;
        logic [7:0] exp;
        exp_q.push_back(model_read(addr));
        start_frame(1'b0);
        for (int i = 0; i < 5; i++) drive_slot(addr[i]);
        check("rw_before_load", {7'd0, rw_flag}, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            got[k] = dout;
            check("rw_during_data", {7'd0, rw_flag}, 8'h01);
            din = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("rw_after_frame", {7'd0, rw_flag}, 8'h00);
        check("dout_after_frame", {7'd0, dout}, 8'h00);
        exp = exp_q.pop_front();
        check("read_data", got, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [12:0] wr_vec [9];
        wr_vec[0] = 13'h0A2; wr_vec[1] = 13'h15D; wr_vec[2] = 13'h283;
        wr_vec[3] = 13'h3C6; wr_vec[4] = 13'h433; wr_vec[5] = 13'h52B;
        wr_vec[6] = 13'h635; wr_vec[7] = 13'h715; wr_vec[8] = 13'h847;

        rst = 1'b1; strobe = 1'b0; wr_en = 1'b0; din = 1'b0;
        for (int i = 0; i < 8; i++) rd_m[i] = 8'h00;
        for (int i = 0; i < 9; i++) cfg_m[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cfg("reset_cfg");
        check("reset_dout", {7'd0, dout}, 8'h00);
        check("reset_rw", {7'd0, rw_flag}, 8'h00);
        rst = 1'b0;

        // Fill all read/write registers, then read them back
        for (int i = 0; i < 9; i++) do_write(wr_vec[i][12:8], wr_vec[i][7:0]);
        check_cfg("write_all");
        for (int i = 0; i < 9; i++) do_read(5'(i));

        // Read-only status: writes ignored, reads return rd_n
        for (int i = 0; i < 8; i++) rd_m[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) do_write(5'(9 + i), 8'($urandom_range(0, 255)));
        check_cfg("ro_write_ignored");
        for (int i = 0; i < 8; i++) do_read(5'(9 + i));

        // Unmapped address
        do_write(5'd20, 8'h5A);
        check_cfg("unmapped_write");
        do_read(5'd20);

        // Aborted write: strobe on slot 7 restarts as a write of 0x1FF
        start_frame(1'b1);
        for (int i = 0; i < 6; i++) drive_slot(1'b1);
        do_write(5'd1, 8'hFF);
        check_cfg("abort_then_write");

        // Reset mid-frame, with strobe also high: no commit, registers clear
        start_frame(1'b1);
        for (int i = 0; i < 6; i++) drive_slot(1'($urandom_range(0, 1)));
        @(negedge clk);
        rst = 1'b1; strobe = 1'b1; wr_en = 1'b1;
        @(negedge clk);
        rst = 1'b0; strobe = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 9; i++) cfg_m[i] = 8'h00;
        check_cfg("mid_frame_reset");
        check("reset_rw_mid", {7'd0, rw_flag}, 8'h00);
        do_read(5'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
